// File: rtl/mux_n21_rr_pkg.sv
// Shared definitions for the mux_n21_rr registered N:1 multiplexer.
// Contains the mode encodings, the round-robin search helper and the parity helper.
package mux_n21_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bounds that the helper functions are sized for.
  localparam int MAX_CH = 16;
  localparam int MAX_W  = 256;

  typedef struct packed {
    logic       gnt;
    logic [3:0] idx;
  } rr_res_t;

  // Search last+1, last+2, ... (mod num_ch) for the first valid channel.
  // The channel equal to last is visited at the end of the scan.
  function automatic rr_res_t next_rr(input logic [MAX_CH-1:0] valid,
                                      input logic [3:0]        last,
                                      input int                num_ch);
    rr_res_t res;
    int      c;
    res = '0;
    for (int i = 1; i <= MAX_CH; i++) begin
      c = (int'(last) + i) % num_ch;
      if (i <= num_ch && !res.gnt && valid[c[3:0]]) begin
        res.gnt = 1'b1;
        res.idx = c[3:0];
      end
    end
    return res;
  endfunction

  // Even parity: XOR reduction of the word (zero-extended by the caller).
  function automatic logic parity(input logic [MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mux_n21_rr_arb.sv
// Combinational grant generator for mux_n21_rr.
// Fixed mode grants sel_i if that channel exists and is valid; round-robin
// mode grants the next valid channel after last_i.
module mux_n21_rr_arb
  import mux_n21_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] in_valid_i,
  input  logic [SEL_W-1:0]  last_i,
  input  logic              mode_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic              grant_o,
  output logic [SEL_W-1:0]  idx_o
);

  logic [MAX_CH-1:0] valid_pad;
  logic [3:0]        last_pad;
  logic [3:0]        sel_pad;
  rr_res_t           rr;

  assign valid_pad = MAX_CH'(in_valid_i);
  assign last_pad  = 4'(last_i);
  assign sel_pad   = 4'(sel_i);

  // Pick the granted channel for the active mode; no grant by default.
  always_comb begin
    grant_o = 1'b0;
    idx_o   = '0;
    rr      = next_rr(valid_pad, last_pad, NUM_CH);
    if (mode_i == MODE_RR) begin
      grant_o = rr.gnt;
      idx_o   = SEL_W'(rr.idx);
    end else begin
      idx_o = sel_i;
      if (int'(sel_pad) < NUM_CH && valid_pad[sel_pad]) begin
        grant_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n21_rr.sv
// Registered N:1 multiplexer with valid/ready on every input and the output,
// fixed-select or round-robin channel choice, one output register stage.
// Optional MUX_N21_RR_PARITY_EN adds a registered even-parity output OutParity.
module mux_n21_rr
  import mux_n21_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_CH*WIDTH-1:0] In,
  input  logic [NUM_CH-1:0]       InValid,
  output logic [NUM_CH-1:0]       InReady,
  input  logic                    Mode,
  input  logic [SEL_W-1:0]        Sel,
  output logic [WIDTH-1:0]        Out,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [SEL_W-1:0]        OutCh
`ifdef MUX_N21_RR_PARITY_EN
  ,
  output logic                    OutParity
`endif
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             grant;
  logic [SEL_W-1:0] gnt_idx;
  logic             load;
  logic             take;
  logic [WIDTH-1:0] ch_data [NUM_CH];

  mux_n21_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .in_valid_i (InValid),
    .last_i     (last_q),
    .mode_i     (Mode),
    .sel_i      (Sel),
    .grant_o    (grant),
    .idx_o      (gnt_idx)
  );

  // Output register can take a word when empty or being drained this cycle.
  assign load = !out_valid_q || OutReady;
  assign take = load && grant;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi] = In[gi*WIDTH +: WIDTH];
      assign InReady[gi] = take && !Reset && (gnt_idx == SEL_W'(gi));
    end
  endgenerate

  // Next-state: OutValid is the EMPTY/FULL state; a transfer loads data and channel.
  always_comb begin
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (load) begin
      out_valid_d = grant;
    end
    if (take) begin
      out_d    = ch_data[gnt_idx];
      out_ch_d = gnt_idx;
      if (Mode == MODE_RR) begin
        last_d = gnt_idx;
      end
    end
  end

  // Output stage and round-robin pointer; pointer resets so channel 0 wins first.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      last_q      <= SEL_W'(NUM_CH - 1);
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
    end
  end

  assign Out      = out_q;
  assign OutValid = out_valid_q;
  assign OutCh    = out_ch_q;

`ifdef MUX_N21_RR_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = take ? parity(MAX_W'(ch_data[gnt_idx])) : parity_q;

  // Parity bit travels with the loaded word.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign OutParity = parity_q;
`endif

endmodule

// File: tb/tb_mux_n21_rr.sv
// Directed bench for mux_n21_rr (NUM_CH=4, WIDTH=8) with a scoreboard queue
// filled by the stimulus and drained by an output monitor.
module tb_mux_n21_rr;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int SEL_W  = 2;

  logic                    Clk = 1'b0;
  logic                    Reset;
  logic [NUM_CH*WIDTH-1:0] In;
  logic [NUM_CH-1:0]       InValid;
  logic [NUM_CH-1:0]       InReady;
  logic                    Mode;
  logic [SEL_W-1:0]        Sel;
  logic [WIDTH-1:0]        Out;
  logic                    OutValid;
  logic                    OutReady;
  logic [SEL_W-1:0]        OutCh;
`ifdef MUX_N21_RR_PARITY_EN
  logic                    OutParity;
`endif

  mux_n21_rr #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .In       (In),
    .InValid  (InValid),
    .InReady  (InReady),
    .Mode     (Mode),
    .Sel      (Sel),
    .Out      (Out),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutCh    (OutCh)
`ifdef MUX_N21_RR_PARITY_EN
    ,
    .OutParity(OutParity)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Channel payloads used in the round-robin scenarios.
  logic [7:0] dat [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
  int seq2 [5] = '{0, 1, 2, 3, 0};
  int seq3 [4] = '{3, 1, 3, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input int ch);
    exp_t e;
    e.data = d;
    e.ch   = 2'(ch);
    sb.push_back(e);
  endtask

  // Monitor: every accepted output word is compared with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Reset && OutValid && OutReady) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got ch=%0d data=%02h, required no output", OutCh, Out);
        end else begin
          e = sb.pop_front();
          $display("xfer ch=%0d data=%02h (req ch=%0d data=%02h)", OutCh, Out, e.ch, e.data);
          chk("out_data", 32'(Out), 32'(e.data));
          chk("out_ch", 32'(OutCh), 32'(e.ch));
`ifdef MUX_N21_RR_PARITY_EN
          chk("out_parity", 32'(OutParity), 32'(^e.data));
`endif
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    Reset    = 1'b1;
    In       = '0;
    InValid  = 4'b1111;
    Mode     = 1'b1;
    Sel      = '0;
    OutReady = 1'b1;
    step();
    step();
    // Reset state, with inputs requesting service
    chk("rst_out", 32'(Out), 32'h0);
    chk("rst_valid", 32'(OutValid), 32'h0);
    chk("rst_ch", 32'(OutCh), 32'h0);
    chk("rst_inready", 32'(InReady), 32'h0);
    Reset   = 1'b0;

    // 1. Fixed mode, Sel=2
    Mode    = 1'b0;
    Sel     = 2'd2;
    In      = 32'h00A5_0000;
    InValid = 4'b0100;
    #1;
    chk("t1_inready", 32'(InReady), 32'h4);
    push(8'hA5, 2);
    step();
    InValid = 4'b0000;
    #1;
    chk("t1_valid", 32'(OutValid), 32'h1);
    chk("t1_out", 32'(Out), 32'hA5);
    chk("t1_ch", 32'(OutCh), 32'h2);
    step();

    // 2. Round-robin, all valid: 0,1,2,3,0
    In      = {dat[3], dat[2], dat[1], dat[0]};
    Mode    = 1'b1;
    InValid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_inready", 32'(InReady), 32'(1 << seq2[i]));
      push(dat[seq2[i]], seq2[i]);
      step();
    end

    // 3. Move pointer to 1, then 1010 alternates 3,1,3,1
    InValid = 4'b0010;
    #1;
    chk("t3_setup", 32'(InReady), 32'h2);
    push(dat[1], 1);
    step();
    InValid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_inready", 32'(InReady), 32'(1 << seq3[i]));
      push(dat[seq3[i]], seq3[i]);
      step();
    end

    // 4. Backpressure on word 3C
    In      = {dat[3], dat[2], dat[1], 8'h3C};
    Mode    = 1'b0;
    Sel     = 2'd0;
    InValid = 4'b0001;
    #1;
    chk("t4_inready", 32'(InReady), 32'h1);
    push(8'h3C, 0);
    step();
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_hold_valid", 32'(OutValid), 32'h1);
      chk("t4_hold_out", 32'(Out), 32'h3C);
      chk("t4_hold_ready", 32'(InReady), 32'h0);
      step();
    end
    OutReady = 1'b1;
    InValid  = 4'b0000;
    #1;
    chk("t4_drain_ready", 32'(InReady), 32'h0);
    step();
    chk("t4_empty", 32'(OutValid), 32'h0);

    // 5. Fresh reset, fixed Sel=2 on 1011 gives nothing, RR then grants 0
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    step();
    Mode    = 1'b0;
    Sel     = 2'd2;
    InValid = 4'b1011;
    #1;
    chk("t5_no_grant", 32'(InReady), 32'h0);
    step();
    chk("t5_still_empty", 32'(OutValid), 32'h0);
    Mode = 1'b1;
    #1;
    chk("t5_rr_grant", 32'(InReady), 32'h1);
    push(8'h3C, 0);
    step();

    // 6. Async reset while a word is held
    In      = {dat[3], dat[2], dat[1], dat[0]};
    InValid = 4'b1111;
    #1;
    chk("t6_grant1", 32'(InReady), 32'h2);
    push(dat[1], 1);
    step();
    #2;
    Reset = 1'b1;
    #1;
    chk("t6_rst_out", 32'(Out), 32'h0);
    chk("t6_rst_valid", 32'(OutValid), 32'h0);
    chk("t6_rst_inready", 32'(InReady), 32'h0);
    void'(sb.pop_back());
    step();
    Reset = 1'b0;
    #1;
    chk("t6_first_grant", 32'(InReady), 32'h1);
    push(dat[0], 0);
    step();

    // Load 07 on channel 1 (odd parity word)
    In      = {dat[3], dat[2], 8'h07, dat[0]};
    InValid = 4'b0010;
    #1;
    chk("t6_grant_07", 32'(InReady), 32'h2);
    push(8'h07, 1);
    step();
    InValid = 4'b0000;
    #1;
    chk("t6_out_07", 32'(Out), 32'h07);
`ifdef MUX_N21_RR_PARITY_EN
    chk("t6_parity_07", 32'(OutParity), 32'h1);
`endif
    step();
    step();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mux_n21_rr.md
Name: mux_n21_rr

Overview:
Parametrised N-channel, WIDTH-bit registered multiplexer. It is the successor to the team's fixed 4:1 structural mux and adds a valid/ready handshake on every input and on the output.
Two selection modes:
- Fixed: the Sel port chooses the channel.
- Round-robin: the block scans for the next valid input channel.
It sits between several producer channels and a single downstream consumer. There is one output register stage.

Parameters:
NUM_CH, 4, number of input channels (2..16).
WIDTH, 8, data width per channel.
SEL_W, $clog2(NUM_CH), localparam, width of channel index.

Ports:
Clk  input  1  clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
In  input  NUM_CH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
InValid  input  NUM_CH  per-channel data valid.
InReady  output  NUM_CH  per-channel accept; one-hot or zero.
Mode  input  1  0 = fixed select, 1 = round-robin.
Sel  input  SEL_W  channel index used in fixed mode.
Out  output  WIDTH  registered output data.
OutValid  output  1  Out holds valid data.
OutReady  input  1  consumer accepts Out.
OutCh  output  SEL_W  index of the channel that supplied Out.

Behaviour:
- Reset (async assert, sync-safe deassert): Out=0, OutValid=0, OutCh=0, round-robin pointer Last=NUM_CH-1, so channel 0 wins first. InReady=0 while Reset is high.
- Load enable: load = !OutValid || OutReady. The output register only accepts new data when it is empty or being drained in the same cycle.
- Grant in fixed mode:
  - g = Sel when Sel < NUM_CH and InValid[Sel]=1; otherwise no grant.
  - Sel >= NUM_CH never grants and never raises InReady.
- Grant in round-robin mode:
  - g = first k with InValid[k]=1, searching Last+1, Last+2, … with wrap modulo NUM_CH.
  - Last itself is checked last.
  - No valid inputs means no grant.
- InReady[g] = load && grant. All other InReady bits are 0. Grant and InReady are combinational from the current inputs and the current state.
- Transfer on channel g occurs when InValid[g] && InReady[g]. On the next edge: Out=In[g], OutCh=g, OutValid=1. In round-robin mode only, Last is set to g.
- Last is not modified in fixed mode. Switching Mode resumes round-robin from the stored Last.
- No grant while load=1: on the next edge OutValid=0. Out and OutCh hold their old values; they are don't-care for the consumer.
- Backpressure: while OutValid=1 and OutReady=0, Out, OutCh and OutValid hold stable and all InReady=0.
- Full throughput: one word per cycle when OutReady is held at 1. Latency is 1 cycle from input transfer to OutValid.
- Simultaneous drain and load: OutReady=1 with a grant replaces the word in the same edge, with no bubble.
- Mode and Sel changes take effect on the next grant evaluation. No word in flight is affected.
- Reset mid-operation: any held word is discarded and the pointer returns to NUM_CH-1.
- Implicit two-state FSM held in OutValid:
  - EMPTY goes to FULL on a grant.
  - FULL stays FULL on (OutReady && grant) or !OutReady.
  - FULL goes to EMPTY on (OutReady && !grant).

Optional Feature:
MUX_N21_RR_PARITY_EN
- When defined: adds output port OutParity (1 bit). It is registered alongside Out, equals the XOR-reduction of the loaded word (even parity), and resets to 0.
- When undefined: the port and its logic are absent.

Decomposition:
- Package mux_n21_pkg holds:
  - mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - a function next_rr(valid, last, NUM_CH) returning grant-valid and index;
  - a parity function.
- One sub-module, mux_n21_rr_arb: a combinational grant generator. Inputs are InValid, Last, Mode and Sel; outputs are grant-valid and index g. The top level holds the registers and the data mux.

Test Plan:
All scenarios use NUM_CH=4, WIDTH=8.
1. Reset, then fixed mode, Sel=2, In[2]=8'hA5, InValid=4'b0100, OutReady=1 -> InReady=4'b0100; next cycle Out=8'hA5, OutCh=2, OutValid=1.
2. Round-robin mode, InValid=4'b1111 held, OutReady=1 -> OutCh sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
3. Round-robin mode, InValid=4'b1010, Last=1 -> grant order 3,1,3,1; channels 0 and 2 are never granted.
4. Backpressure: OutValid=1 with Out=8'h3C, OutReady=0 for 3 cycles -> Out stays 8'h3C, InReady=0 throughout; OutReady=1 with no valid inputs -> OutValid=0 on the next cycle.
5. Fixed mode, Sel=2 with InValid=4'b1011 -> no grant, InReady=0, OutValid stays 0. Switch to Mode=1 -> grant goes to channel 0 (pointer unchanged from reset).
6. Assert Reset asynchronously mid-stream while OutValid=1 -> Out=0, OutValid=0, InReady=0 immediately. After deassertion the first round-robin grant is channel 0. With MUX_N21_RR_PARITY_EN defined, loading 8'h07 gives OutParity=1.
